// File: rtl/mux_4_1_rr_sched.sv
// mux_4_1_rr_sched
// Round-robin scheduler sharing one 4:1 DW-bit mux between four requesters.
// A grant is held until its requester drops or HOLD cycles elapse. It then
// rotates to the next requester after the rotating priority pointer, with no
// idle bubble between grants.
module mux_4_1_rr_sched #(
  parameter int DW   = 2,
  parameter int HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  output logic [1:0]    sel,
  output logic [3:0]    grant,
  output logic [DW-1:0] y,
  output logic          busy,
  output logic [7:0]    hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_C = 8'(HOLD);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] grant_nxt;
  logic [7:0] cnt_nxt;

  logic [3:0] arb_req;
  logic [1:0] next_lane;
  logic       timeout;
  logic       release_now;

  // First requesting lane at or after the priority pointer, wrapping mod 4.
  // The loop scans the farthest offset first so that the nearest hit wins.
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  // While a lane is granted, it is masked out so that a release hands over
  // to another lane whenever anyone else is waiting.
  always_comb begin
    arb_req     = (state == IDLE) ? req : (req & ~grant);
    next_lane   = pick(ptr, arb_req);
    timeout     = (hold_cnt == HOLD_C);
    release_now = !req[sel] || timeout;
  end

  // Next-state logic: start, hold, hand over, re-grant or return to idle.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    grant_nxt = grant;
    cnt_nxt   = hold_cnt;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = next_lane;
          grant_nxt = 4'b0001 << next_lane;
          cnt_nxt   = 8'd1;
          ptr_nxt   = next_lane + 2'd1;
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_nxt = hold_cnt + 8'd1;
        end else if (|arb_req) begin
          sel_nxt   = next_lane;
          grant_nxt = 4'b0001 << next_lane;
          cnt_nxt   = 8'd1;
          ptr_nxt   = next_lane + 2'd1;
        end else if (req[sel]) begin
          cnt_nxt = 8'd1;
          ptr_nxt = sel + 2'd1;
        end else begin
          state_nxt = IDLE;
          grant_nxt = 4'b0000;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State register with synchronous reset back to idle and pointer zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'd0;
      grant    <= 4'b0000;
      hold_cnt <= 8'd0;
      ptr      <= 2'd0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      grant    <= grant_nxt;
      hold_cnt <= cnt_nxt;
      ptr      <= ptr_nxt;
    end
  end

  assign busy = (state == GRANT);

  // Shared mux: live lane data passes straight through; output is zero when idle.
  always_comb begin
    y = '0;
    if (|grant) begin
      case (sel)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4_1_rr_sched.sv
// tb_mux_4_1_rr_sched
// Drives directed and randomized request patterns into the scheduler and
// compares every cycle against a lane/counter/pointer reference model.
module tb_mux_4_1_rr_sched;

  localparam int DW   = 2;
  localparam int HOLD = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] d0, d1, d2, d3;
  logic [1:0]    sel;
  logic [3:0]    grant;
  logic [DW-1:0] y;
  logic          busy;
  logic [7:0]    hold_cnt;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: who holds the mux, for how long, and whose turn is next.
  bit m_active = 0;
  int m_lane   = 0;
  int m_cnt    = 0;
  int m_ptr    = 0;

  mux_4_1_rr_sched #(.DW(DW), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .sel(sel), .grant(grant), .y(y), .busy(busy), .hold_cnt(hold_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Lane data the model expects to see on the shared output.
  function automatic logic [31:0] lane_data(input int lane);
    case (lane)
      0:       return 32'(d0);
      1:       return 32'(d1);
      2:       return 32'(d2);
      default: return 32'(d3);
    endcase
  endfunction

  // Walks from the pointer around the ring and returns the first requester.
  function automatic int first_from(input int p, input logic [3:0] r);
    for (int off = 0; off < 4; off++)
      if (r[(p + off) % 4]) return (p + off) % 4;
    return p;
  endfunction

  // Compares all DUT outputs against the model in its present state.
  task automatic compareAll(input string when);
    checkOutput({when, ".grant"}, 32'(grant), m_active ? (32'd1 << m_lane) : 32'd0);
    checkOutput({when, ".sel"},   32'(sel),   32'(m_lane));
    checkOutput({when, ".busy"},  32'(busy),  32'(m_active));
    checkOutput({when, ".hold"},  32'(hold_cnt), 32'(m_cnt));
    checkOutput({when, ".y"},     32'(y),     m_active ? lane_data(m_lane) : 32'd0);
  endtask

  // One cycle: check current outputs, drive new inputs, check mux pass-through,
  // then advance the model to what the next rising edge should produce.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input bit rand_data);
    logic [3:0] others;
    bit         done;
    @(negedge clk);
    compareAll("state");
    rst = r;
    req = rq;
    if (rand_data) begin
      d0 = DW'($urandom); d1 = DW'($urandom);
      d2 = DW'($urandom); d3 = DW'($urandom);
    end
    #1;
    checkOutput("passthru.y", 32'(y), m_active ? lane_data(m_lane) : 32'd0);
    if (r) begin
      m_active = 0; m_lane = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_active) begin
      if (rq != 4'b0000) begin
        m_lane   = first_from(m_ptr, rq);
        m_active = 1;
        m_cnt    = 1;
        m_ptr    = (m_lane + 1) % 4;
      end
    end else begin
      done = !rq[m_lane] || (m_cnt == HOLD);
      if (!done) begin
        m_cnt = m_cnt + 1;
      end else begin
        others = rq;
        others[m_lane] = 1'b0;
        if (others != 4'b0000) begin
          m_lane = first_from(m_ptr, others);
          m_cnt  = 1;
          m_ptr  = (m_lane + 1) % 4;
        end else if (rq[m_lane]) begin
          m_cnt = 1;
          m_ptr = (m_lane + 1) % 4;
        end else begin
          m_active = 0;
          m_cnt    = 0;
        end
      end
    end
  endtask

  // Stimulus sequence: directed scenarios first, then a long random run.
  initial begin
    logic [3:0] rq;
    rst = 1'b1;
    req = 4'b0000;
    d0 = 2'b00; d1 = 2'b01; d2 = 2'b10; d3 = 2'b11;

    // Reset, then an idle stretch with nobody requesting.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b0000, 1'b0);

    // A single requester held high re-grants itself every HOLD cycles.
    d1 = 2'b10;
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);

    // All four requesting: fair rotation with no idle gap.
    d0 = 2'b00; d1 = 2'b01; d2 = 2'b10; d3 = 2'b11;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'b1111, 1'b0);

    // Early release of lane 2 hands over to lane 3, then to idle.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1001, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 1'b0);

    // A late request on lane 3 waits for lane 0 to time out.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b1001, 1'b0);

    // Reset in the middle of a lane 3 grant restarts arbitration at lane 0.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b1111, 1'b0);

    // Random run: sticky requests, random data and occasional resets.
    rq = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 4) == 0) rq[b] = ~rq[b];
      applyStimulus(($urandom_range(0, 59) == 0), rq, 1'b1);
    end

    @(negedge clk);
    compareAll("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mux_4_1_rr_sched.md
Name: mux_4_1_rr_sched

Overview:
- Round-robin scheduler that shares one 4:1 DW-bit multiplexer between four requesters.
- Each requester owns one data lane (d0..d3).
- The block decides which lane drives the shared output and for how long, and it drives the mux select and a one-hot grant.
- It sits between the board inputs (switch lanes, KEY-derived requests) and the LED output path. It replaces static KEY-driven select with timed, fair sharing.

Parameters:
- DW, 2, width of each data lane and of y.
- HOLD, 4, maximum consecutive cycles one grant is held (range 1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request per lane; req[i] belongs to d<i>.
- d0  input  DW  lane 0 data.
- d1  input  DW  lane 1 data.
- d2  input  DW  lane 2 data.
- d3  input  DW  lane 3 data.
- sel  output  2  registered mux select (index of current/last grantee).
- grant  output  4  registered one-hot grant; all-zero when idle.
- y  output  DW  muxed data: d[sel] when any grant bit is set, else 0.
- busy  output  1  high while in GRANT state (equals |grant).
- hold_cnt  output  8  cycles the current grant has been held, for debug.

Behaviour:
- One clock; rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - State = IDLE, sel = 0, grant = 0000, busy = 0, hold_cnt = 0.
  - Priority pointer ptr = 0.
  - y = 0 because grant is zero.
- Arbitration function: next = the first i with req[i] = 1, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
- State IDLE:
  - If req != 0, go to GRANT with sel = next, grant = onehot(next), hold_cnt = 1, ptr = next+1 mod 4.
  - Otherwise stay in IDLE.
  - Latency: grant appears on the first clock edge after req is seen high (1 cycle).
- State GRANT, evaluated every cycle. Release condition: req[sel] = 0 (early release) OR hold_cnt = HOLD (timeout).
  - No release: hold_cnt increments; sel and grant are unchanged.
  - Release, and req with the current lane masked off is non-zero: switch directly to next (computed from ptr) the same edge, with no idle bubble. hold_cnt = 1, ptr advances.
  - Release on timeout, and only req[sel] is still high: re-grant the same lane. hold_cnt = 1, ptr = sel+1 mod 4.
  - Release, and req = 0: go to IDLE. grant = 0000, hold_cnt = 0; sel keeps its last value.
- y is combinational from registered sel/grant and live d inputs, so data changes on d[sel] pass through in the same cycle.
- Requests rising mid-grant never preempt; they are served only at release.
- Fairness: with all four requests held high, grants rotate 0,1,2,3,0,... Each grant lasts exactly HOLD cycles.
- HOLD = 1: every granted lane gets one cycle, then rotation.
- hold_cnt width is 8; it never exceeds HOLD, so no wrap-around.
- rst asserted mid-grant: the next edge forces all reset values. Outstanding requests are re-arbitrated from ptr = 0 on the first cycle after rst deasserts.
- req is assumed synchronous to clk; the block does not synchronise it (the top level does).

Test Plan:
1. Reset, then req = 0000 for 10 cycles -> grant = 0000, busy = 0, y = 00, sel = 0 throughout.
2. HOLD = 4, d1 = 2'b10, req = 0010 held -> grant = 0010 one cycle later. hold_cnt counts 1,2,3,4, then re-grants lane 1 with hold_cnt = 1. y = 10 continuously.
3. HOLD = 4, req = 1111, d0..d3 = 00,01,10,11 -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001... y steps 00,01,10,11 with no idle cycle between grants.
4. Grant on lane 2, drop req[2] at hold_cnt = 2 while req = 1001 -> next edge grant = 1000 (ptr was 3), hold_cnt = 1. With req = 0000 instead -> IDLE, grant = 0000, y = 00, sel stays 2.
5. Lane 0 granted, req[3] rises at hold_cnt = 1 -> no preemption; lane 3 is granted only after lane 0 reaches hold_cnt = 4.
6. rst pulsed for one cycle while lane 3 is granted with req = 1111 -> following edge grant = 0000, ptr = 0. After release, grant = 0001 first.
